ask_demod: RTL and testbench
============================

ASK_DEMOD -- requirements
Module: ask_demod

Interface
REQ-001 Parameter SAMP_PER_BIT, default 100, sets samples per bit symbol (4 carrier periods of 25 samples); legal range 2..255.
REQ-002 clk  input  1  sole clock; all logic on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 din  input  12  signed two's-complement received ASK sample.
REQ-005 din_valid  input  1  din is valid this cycle.
REQ-006 sync  input  1  single-cycle pulse marking the first sample of a bit symbol.
REQ-007 thr  input  20  unsigned decision threshold on the per-symbol magnitude sum.
REQ-008 bit_out  output  1  decoded bit, held until the next decision.
REQ-009 bit_valid  output  1  one-cycle pulse; a new bit_out is presented.
REQ-010 busy  output  1  high while a symbol is partially accumulated.

Function
REQ-011 Each accepted sample (din_valid=1) SHALL contribute its magnitude |din| (13-bit unsigned; |-2048| = 2048, no saturation) to a 20-bit accumulator.
REQ-012 An 8-bit sample counter SHALL count accepted samples from 0 to SAMP_PER_BIT-1; cycles with din_valid=0 SHALL leave the counter and accumulator unchanged.
REQ-013 On the accepted sample with counter = SAMP_PER_BIT-1, the full sum (accumulator + |din|) SHALL be compared with thr: bit_out = 1 if sum > thr (strict), else 0.
REQ-014 bit_out and bit_valid SHALL be registered: bit_valid rises exactly one clk after the last sample of the symbol is accepted and lasts one cycle.
REQ-015 On that same last-sample edge the counter and accumulator SHALL wrap to 0, so back-to-back symbols need no idle cycle.
REQ-016 sync=1 SHALL discard any partial symbol (no bit_valid for it); if din_valid=1 in the same cycle that sample becomes sample 0 of the new symbol, otherwise counter and accumulator become 0.
REQ-017 sync on the cycle that would complete a symbol SHALL take priority: no decision, sample counted as sample 0.
REQ-018 thr SHALL be sampled only at the decision edge; changes mid-symbol have no other effect.
REQ-019 busy SHALL equal (counter != 0).
REQ-020 The accumulator SHALL never overflow: max 255 x 2048 = 522240 < 2^20.

Reset
REQ-021 rst_n=0 SHALL asynchronously clear counter, accumulator, bit_out, bit_valid and busy to 0.
REQ-022 Reset released mid-symbol SHALL start a fresh symbol at the first accepted sample; no bit_valid for the interrupted symbol.

Configuration
REQ-023 Macro ASK_DEMOD_CNT_EN defined: extra output ones_cnt [15:0], reset 0, increments on each bit_valid with bit_out=1, wraps 65535 -> 0.
REQ-024 Macro ASK_DEMOD_CNT_EN undefined: port ones_cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-025 sync + 100 valid samples din=100, thr=9999 -> one bit_valid, bit_out=1, exactly 1 cycle after the 100th sample.
REQ-026 Same stimulus, thr=10000 -> bit_out=0 (strict compare); din=-2048 x100, thr=204799 -> bit_out=1.
REQ-027 100 samples with din_valid deasserted every other cycle -> identical decision to REQ-025, bit_valid after the 100th accepted sample only.
REQ-028 50 samples, then sync with din_valid=1, then 99 more -> no bit_valid at sample 50 region; single bit_valid after the 100th sample of the new symbol.
REQ-029 Two contiguous symbols (carrier amplitude ~2043 then din=0), thr=65000 -> bit_out 1 then 0, bit_valid pulses exactly 100 accepted samples apart.
REQ-030 rst_n pulsed low at sample 60 -> all outputs 0 immediately; next 100 samples produce one decision; with ASK_DEMOD_CNT_EN, ones_cnt counts 1-bits and returns to 0 on reset.

Source files
------------

// File: rtl/ask_demod.sv
// ASK demodulator: integrates |din| over each bit symbol and slices the sum against thr.
// Optional `ASK_DEMOD_CNT_EN adds a 16-bit ones_cnt output counting decided 1-bits.
module ask_demod #(
    parameter int unsigned SAMP_PER_BIT = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [11:0] din,
    input  logic               din_valid,
    input  logic               sync,
    input  logic        [19:0] thr,
    output logic               bit_out,
    output logic               bit_valid,
    output logic               busy
`ifdef ASK_DEMOD_CNT_EN
    ,
    output logic        [15:0] ones_cnt
`endif
);

    localparam int unsigned CW = 8;
    localparam int unsigned AW = 20;
    localparam int unsigned MW = 13;
    localparam logic [CW-1:0] LAST_IDX = CW'(SAMP_PER_BIT - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_nxt;
    logic [AW-1:0] sum_c;
    logic [MW-1:0] din_ext;
    logic [MW-1:0] mag;
    logic          last_c;
    logic          dec_c;

    // Magnitude is one bit wider than din so that |-2048| is exact.
    always_comb begin
        din_ext = {din[11], din};
        mag     = din[11] ? (~din_ext + MW'(1)) : din_ext;
        sum_c   = acc + AW'(mag);
        last_c  = din_valid && !sync && (cnt == LAST_IDX);
        dec_c   = (sum_c > thr);
    end

    // sync restarts the symbol and outranks completion; the last sample wraps to 0.
    always_comb begin
        cnt_nxt = cnt;
        acc_nxt = acc;
        if (sync) begin
            cnt_nxt = din_valid ? CW'(1) : '0;
            acc_nxt = din_valid ? AW'(mag) : '0;
        end else if (din_valid) begin
            if (cnt == LAST_IDX) begin
                cnt_nxt = '0;
                acc_nxt = '0;
            end else begin
                cnt_nxt = cnt + CW'(1);
                acc_nxt = sum_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            acc       <= acc_nxt;
            busy      <= (cnt_nxt != '0);
            bit_valid <= last_c;
            if (last_c) begin
                bit_out <= dec_c;
            end
        end
    end

`ifdef ASK_DEMOD_CNT_EN
    // Advances on the same edge that presents a 1-bit decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt <= '0;
        end else if (last_c && dec_c) begin
            ones_cnt <= ones_cnt + 16'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ask_demod.sv
// Directed self-checking bench for ask_demod (default SAMP_PER_BIT = 100).
module tb_ask_demod;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [11:0] din;
    logic               din_valid;
    logic               sync;
    logic        [19:0] thr;
    logic               bit_out;
    logic               bit_valid;
    logic               busy;
`ifdef ASK_DEMOD_CNT_EN
    logic        [15:0] ones_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int nv    = 0;

    ask_demod #(.SAMP_PER_BIT(100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .sync      (sync),
        .thr       (thr),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy)
`ifdef ASK_DEMOD_CNT_EN
        ,
        .ones_cnt  (ones_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then look at the registered outputs just after the edge.
    task automatic tick(input logic signed [11:0] d, input logic v, input logic s);
        din       = d;
        din_valid = v;
        sync      = s;
        @(posedge clk);
        #1;
        if (bit_valid) nv++;
    endtask

    // n accepted samples; carrier alternates sign, gaps inserts an invalid cycle after each.
    task automatic send_n(input int n, input logic signed [11:0] d, input bit carrier,
                          input bit gaps, input bit first_sync);
        for (int i = 0; i < n; i++) begin
            tick((carrier && i[0]) ? -d : d, 1'b1, first_sync && (i == 0));
            if (gaps) tick(12'sh7ff, 1'b0, 1'b0);
        end
    endtask

    // Full 100-sample symbol; checks no early decision and a decision right after sample 100.
    task automatic symbol(input string tag, input logic signed [11:0] d, input bit carrier,
                          input bit gaps, input bit first_sync, input logic exp_bit);
        nv = 0;
        send_n(99, d, carrier, gaps, first_sync);
        check({tag, "_early_valid"}, 32'(nv), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        tick(carrier ? -d : d, 1'b1, 1'b0);
        check({tag, "_valid"}, 32'(bit_valid), 32'd1);
        check({tag, "_bit"}, 32'(bit_out), 32'(exp_bit));
        check({tag, "_busy_wrap"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        sync      = 1'b0;
        thr       = 20'd9999;
        #12;
        check("rst_bit_out", 32'(bit_out), 32'd0);
        check("rst_bit_valid", 32'(bit_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 100 x 100 = 10000 > 9999
        symbol("t025", 12'sd100, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(12'sd0, 1'b0, 1'b0);
        check("t025_pulse_len", 32'(bit_valid), 32'd0);
        check("t025_hold", 32'(bit_out), 32'd1);

        // Strict compare: 10000 is not > 10000
        thr = 20'd10000;
        symbol("t026a", 12'sd100, 1'b0, 1'b0, 1'b1, 1'b0);

        // Invalid cycles between samples are ignored
        thr = 20'd9999;
        symbol("t027", 12'sd100, 1'b0, 1'b1, 1'b1, 1'b1);

        // Partial symbol of large samples discarded by sync
        thr = 20'd10000;
        nv  = 0;
        send_n(50, 12'sd2000, 1'b0, 1'b0, 1'b1);
        symbol("t028", 12'sd100, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t028_one_pulse", 32'(nv), 32'd1);

        // 100 x 2048 = 204800 > 204799
        thr = 20'd204799;
        symbol("t026b", -12'sd2048, 1'b0, 1'b0, 1'b1, 1'b1);

        // sync on the completing sample wins: no decision, sample becomes sample 0
        thr = 20'd10000;
        nv  = 0;
        send_n(99, 12'sd2047, 1'b0, 1'b0, 1'b1);
        tick(12'sd100, 1'b1, 1'b1);
        check("t017_no_valid", 32'(nv), 32'd0);
        check("t017_busy", 32'(busy), 32'd1);
        nv = 0;
        send_n(98, 12'sd100, 1'b0, 1'b0, 1'b0);
        check("t017_early_valid", 32'(nv), 32'd0);
        tick(12'sd100, 1'b1, 1'b0);
        check("t017_valid", 32'(bit_valid), 32'd1);
        check("t017_bit", 32'(bit_out), 32'd0);

        // Contiguous symbols: carrier 100 x 2043 = 204300 -> 1, then zeros -> 0
        thr = 20'd65000;
        symbol("t029a", 12'sd2043, 1'b1, 1'b0, 1'b1, 1'b1);
        symbol("t029b", 12'sd0, 1'b0, 1'b0, 1'b0, 1'b0);

        thr = 20'd9999;
        symbol("t030_pre", 12'sd100, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef ASK_DEMOD_CNT_EN
        check("ones_cnt_pre", 32'(ones_cnt), 32'd5);
`endif

        // Asynchronous reset at sample 60, then a fresh symbol with no sync
        send_n(60, 12'sd2000, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t030_rst_bit", 32'(bit_out), 32'd0);
        check("t030_rst_valid", 32'(bit_valid), 32'd0);
        check("t030_rst_busy", 32'(busy), 32'd0);
`ifdef ASK_DEMOD_CNT_EN
        check("ones_cnt_rst", 32'(ones_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        symbol("t030", 12'sd100, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef ASK_DEMOD_CNT_EN
        check("ones_cnt_post", 32'(ones_cnt), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
